sp_write_arbiter: RTL

SP_WRITE_ARBITER -- requirements
Module: sp_write_arbiter

---
 rtl/sp_write_arbiter_if.sv | 34 +++
 rtl/sp_write_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sp_write_arbiter_if.sv
// Handshake bundle between the ifmap/filter read controllers, the PE and the write arbiter.
// Purely structural: no latency of its own. Backpressure is expressed through the permission and full signals.
interface sp_write_arbiter_if #(
    parameter int AW = 4
);
    logic          valid_if;
    logic          valid_flt;
    logic          done_if;
    logic          done_flt;
    logic          consume_if;
    logic          consume_flt;
    logic          permission_if;
    logic          permission_flt;
    logic [AW-1:0] waddr_if;
    logic [AW-1:0] waddr_flt;
    logic          full_if;
    logic          full_flt;
    logic          empty_if;
    logic          empty_flt;

    // Controller/PE side.
    modport master (
        output valid_if, valid_flt, done_if, done_flt, consume_if, consume_flt,
        input  permission_if, permission_flt, waddr_if, waddr_flt,
        input  full_if, full_flt, empty_if, empty_flt
    );

    // Arbiter side.
    modport slave (
        input  valid_if, valid_flt, done_if, done_flt, consume_if, consume_flt,
        output permission_if, permission_flt, waddr_if, waddr_flt,
        output full_if, full_flt, empty_if, empty_flt
    );
endinterface

// File: rtl/sp_write_arbiter.sv
// Round-robin arbiter granting ifmap/filter controllers write access to their scratchpads.
// Latency: eligible valid in IDLE -> permission on the next cycle; at least one IDLE cycle between grants.
// Backpressure: a side whose scratchpad is full is not eligible; consumes from the PE free entries.
module sp_write_arbiter #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    sp_write_arbiter_if.slave bus
);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IF  = 2'd1,
        GRANT_FLT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          prefer_flt;
    logic [AW:0]   cnt_if;
    logic [AW:0]   cnt_flt;
    logic [AW-1:0] waddr_if;
    logic [AW-1:0] waddr_flt;
    logic          perm_if;
    logic          perm_flt;

    logic          full_if;
    logic          full_flt;
    logic          elig_if;
    logic          elig_flt;
    logic          acc_if;
    logic          acc_flt;
    logic          rel_if;
    logic          rel_flt;
    logic          adv_if;
    logic          adv_flt;

    assign full_if  = (cnt_if == CNT_FULL);
    assign full_flt = (cnt_flt == CNT_FULL);
    assign elig_if  = bus.valid_if && !full_if;
    assign elig_flt = bus.valid_flt && !full_flt;

    // A done only counts while that side holds the grant.
    assign acc_if   = bus.done_if && (state == GRANT_IF);
    assign acc_flt  = bus.done_flt && (state == GRANT_FLT);
    assign rel_if   = bus.consume_if && (cnt_if != '0);
    assign rel_flt  = bus.consume_flt && (cnt_flt != '0);

    // A write landing on a full scratchpad with no simultaneous release is dropped.
    assign adv_if   = acc_if && (!full_if || rel_if);
    assign adv_flt  = acc_flt && (!full_flt || rel_flt);

    always_comb begin
        state_nxt = state;
        perm_if   = 1'b0;
        perm_flt  = 1'b0;
        case (state)
            IDLE: begin
                if (elig_if && elig_flt) begin
                    state_nxt = prefer_flt ? GRANT_FLT : GRANT_IF;
                end else if (elig_if) begin
                    state_nxt = GRANT_IF;
                end else if (elig_flt) begin
                    state_nxt = GRANT_FLT;
                end
            end
            GRANT_IF: begin
                perm_if = 1'b1;
                if (bus.done_if) begin
                    state_nxt = IDLE;
                end
            end
            GRANT_FLT: begin
                perm_flt = 1'b1;
                if (bus.done_flt) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prefer_flt <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GRANT_IF) begin
                prefer_flt <= 1'b1;
            end else if (state == IDLE && state_nxt == GRANT_FLT) begin
                prefer_flt <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_if   <= '0;
            waddr_if <= '0;
        end else begin
            if (adv_if && !rel_if) begin
                cnt_if <= cnt_if + (AW+1)'(1);
            end else if (rel_if && !acc_if) begin
                cnt_if <= cnt_if - (AW+1)'(1);
            end
            if (adv_if) begin
                waddr_if <= (waddr_if == ADDR_LAST) ? '0 : waddr_if + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_flt   <= '0;
            waddr_flt <= '0;
        end else begin
            if (adv_flt && !rel_flt) begin
                cnt_flt <= cnt_flt + (AW+1)'(1);
            end else if (rel_flt && !acc_flt) begin
                cnt_flt <= cnt_flt - (AW+1)'(1);
            end
            if (adv_flt) begin
                waddr_flt <= (waddr_flt == ADDR_LAST) ? '0 : waddr_flt + AW'(1);
            end
        end
    end

    assign bus.permission_if  = perm_if;
    assign bus.permission_flt = perm_flt;
    assign bus.waddr_if       = waddr_if;
    assign bus.waddr_flt      = waddr_flt;
    assign bus.full_if        = full_if;
    assign bus.full_flt       = full_flt;
    assign bus.empty_if       = (cnt_if == '0);
    assign bus.empty_flt      = (cnt_flt == '0);

    a_perm_excl: assert property (@(posedge clk) disable iff (rst)
        !(perm_if && perm_flt));
    a_cnt_if_max: assert property (@(posedge clk) disable iff (rst)
        cnt_if <= CNT_FULL);
    a_cnt_flt_max: assert property (@(posedge clk) disable iff (rst)
        cnt_flt <= CNT_FULL);
endmodule
